daq_arbiter: RTL and testbench



---
 rtl/daq_arbiter.sv | 133 +++++++++++++
 tb/tb_daq_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/daq_arbiter.sv
// daq_arbiter: round-robin grant of the DAQ packet buffer to NDAQ sources, with word counting and stall/overrun abort.
// Optional per-source packet/abort counters are enabled by defining DAQ_ARB_STATS_EN.
module daq_arbiter #(
  parameter int NDAQ      = 4,
  parameter int MAX_WORDS = 64,
  parameter int TIMEOUT   = 1024,
  parameter int FREE_BITS = 13,
  parameter int LEN_BITS  = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NDAQ-1:0]         daq_req,
  input  logic [NDAQ-1:0]         daq_valid,
  input  logic [NDAQ-1:0]         daq_end,
  input  logic [FREE_BITS-1:0]    buf_free,
  output logic [NDAQ-1:0]         daq_grant,
  output logic [$clog2(NDAQ)-1:0] sel,
  output logic                    busy,
  output logic                    wr_en,
  output logic                    len_wr_en,
  output logic [LEN_BITS-1:0]     len,
  output logic                    abort,
  output logic                    abort_cause
`ifdef DAQ_ARB_STATS_EN
  ,
  input  logic [$clog2(NDAQ)-1:0] stat_idx,
  output logic [31:0]             stat_pkts,
  output logic [15:0]             stat_aborts
`endif
);
  localparam int SW = $clog2(NDAQ);
  localparam int WD = $clog2(TIMEOUT);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic [SW-1:0] ptr, ptr_d, sel_d, win;
  logic [NDAQ-1:0] grant_d;
  logic [LEN_BITS-1:0] cnt, cnt_d, len_d;
  logic [WD-1:0] wdog, wdog_d;
  logic found, vld, fin, room, wr_d, lwr_d, ab_d, cause_d;
  // the last loop iteration that hits is the closest set bit at or after ptr
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int k = NDAQ - 1; k >= 0; k--) begin
      if (daq_req[(int'(ptr) + k) % NDAQ]) begin
        found = 1'b1;
        win = SW'((int'(ptr) + k) % NDAQ);
      end
    end
  end
  assign vld = daq_valid[sel];
  assign fin = daq_end[sel];
  assign room = cnt < LEN_BITS'(MAX_WORDS);
  assign busy = state == ACTIVE;
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    sel_d = sel;
    grant_d = '0;
    cnt_d = cnt;
    wdog_d = wdog;
    wr_d = 1'b0;
    lwr_d = 1'b0;
    len_d = len;
    ab_d = 1'b0;
    cause_d = 1'b0;
    if (state == IDLE) begin
      if (found && buf_free >= FREE_BITS'(MAX_WORDS)) begin
        grant_d = NDAQ'(1) << win;
        sel_d = win;
        cnt_d = '0;
        wdog_d = '0;
        state_d = ACTIVE;
      end
    end else begin
      wr_d = vld && room;
      cnt_d = cnt + LEN_BITS'(wr_d);
      wdog_d = vld ? '0 : wdog + 1'b1;
      ab_d = !fin && (vld ? !room : wdog == WD'(TIMEOUT - 1));
      cause_d = ab_d && vld;
      lwr_d = fin || ab_d;
      if (lwr_d) begin
        len_d = cnt_d;
        state_d = IDLE;
        ptr_d = sel == SW'(NDAQ - 1) ? '0 : sel + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      daq_grant <= '0;
      cnt <= '0;
      wdog <= '0;
      wr_en <= 1'b0;
      len_wr_en <= 1'b0;
      len <= '0;
      abort <= 1'b0;
      abort_cause <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      sel <= sel_d;
      daq_grant <= grant_d;
      cnt <= cnt_d;
      wdog <= wdog_d;
      wr_en <= wr_d;
      len_wr_en <= lwr_d;
      len <= len_d;
      abort <= ab_d;
      abort_cause <= cause_d;
    end
  end
`ifdef DAQ_ARB_STATS_EN
  logic [31:0] pkts [NDAQ];
  logic [15:0] aborts [NDAQ];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDAQ; i++) begin
        pkts[i] <= '0;
        aborts[i] <= '0;
      end
    end else if (lwr_d) begin
      if (ab_d) aborts[sel] <= aborts[sel] + 1'b1;
      else pkts[sel] <= pkts[sel] + 1'b1;
    end
  end
  assign stat_pkts = int'(stat_idx) < NDAQ ? pkts[stat_idx] : '0;
  assign stat_aborts = int'(stat_idx) < NDAQ ? aborts[stat_idx] : '0;
`endif
endmodule

// File: tb/tb_daq_arbiter.sv
// tb_daq_arbiter: randomized and directed stimulus checked every cycle against a behavioural arbiter model.
module tb_daq_arbiter;
  localparam int NDAQ = 4, MAXW = 64, TO = 32, FB = 13, LB = 11;
  logic clk = 1'b0, rst_n;
  logic [NDAQ-1:0] daq_req, daq_valid, daq_end, daq_grant;
  logic [FB-1:0] buf_free;
  logic [1:0] sel;
  logic busy, wr_en, len_wr_en, abort, abort_cause;
  logic [LB-1:0] len;
  daq_arbiter #(.NDAQ(NDAQ), .MAX_WORDS(MAXW), .TIMEOUT(TO), .FREE_BITS(FB), .LEN_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .daq_req(daq_req), .daq_valid(daq_valid), .daq_end(daq_end),
    .buf_free(buf_free), .daq_grant(daq_grant), .sel(sel), .busy(busy), .wr_en(wr_en),
    .len_wr_en(len_wr_en), .len(len), .abort(abort), .abort_cause(abort_cause));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_active, m_ptr, m_sel, m_cnt, m_silent;
  int e_grant, e_wr, e_lwr, e_len, e_abort, e_cause;
  int gq[$], lq[$], aq[$];
  int wcnt = 0;
  bit noise_en = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic bound_fail(string n);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", n, $time);
  endtask
  task automatic model_reset();
    m_active = 0; m_ptr = 0; m_sel = 0; m_cnt = 0; m_silent = 0;
    e_grant = 0; e_wr = 0; e_lwr = 0; e_len = 0; e_abort = 0; e_cause = 0;
  endtask
  // one clock of the arbiter's rules, evaluated on the inputs present at the edge
  task automatic model_step();
    bit got, v, e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_grant = 0; e_wr = 0; e_lwr = 0; e_abort = 0; e_cause = 0;
    if (!m_active) begin
      got = 0;
      if (buf_free >= MAXW)
        for (int k = 0; k < NDAQ; k++) begin
          int i;
          i = (m_ptr + k) % NDAQ;
          if (!got && daq_req[i]) begin
            got = 1; m_sel = i; e_grant = 1 << i; m_cnt = 0; m_silent = 0; m_active = 1;
          end
        end
    end else begin
      v = daq_valid[m_sel];
      e = daq_end[m_sel];
      if (v && m_cnt < MAXW) begin e_wr = 1; m_cnt++; end
      m_silent = v ? 0 : m_silent + 1;
      if (e) e_lwr = 1;
      else if (v && !e_wr) begin e_lwr = 1; e_abort = 1; e_cause = 1; end
      else if (m_silent >= TO) begin e_lwr = 1; e_abort = 1; e_cause = 0; end
      if (e_lwr) begin
        e_len = m_cnt; m_active = 0; m_ptr = (m_sel + 1) % NDAQ;
      end
    end
  endtask
  task automatic compare();
    chk("grant", daq_grant, e_grant);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_active);
    chk("wr_en", wr_en, e_wr);
    chk("len_wr_en", len_wr_en, e_lwr);
    chk("abort", abort, e_abort);
    if (e_lwr) chk("len", len, e_len);
    if (e_abort) chk("abort_cause", abort_cause, e_cause);
    if (daq_grant != 0) gq.push_back(sel);
    if (len_wr_en) lq.push_back(len);
    if (abort) aq.push_back(abort_cause);
    if (wr_en) wcnt++;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask
  task automatic set_in(bit v, bit e);
    logic [NDAQ-1:0] b;
    b = NDAQ'(1) << m_sel;
    daq_valid = (noise_en ? NDAQ'($urandom) & ~b : '0) | (v ? b : '0);
    daq_end = (noise_en ? NDAQ'($urandom) & ~b : '0) | (e ? b : '0);
  endtask
  task automatic serve(int nw, bit de, bit mg, bit rnd);
    int n;
    n = 0;
    while (!m_active && n < 300) begin
      if (rnd) buf_free = $urandom_range(0, 1) ? FB'($urandom_range(MAXW, 200)) : FB'($urandom_range(0, MAXW - 1));
      set_in(0, 0);
      cyc();
      n++;
    end
    if (!m_active) begin
      bound_fail("grant_wait");
      return;
    end
    for (int w = 0; w < nw && m_active; w++) begin
      while (rnd && m_active && $urandom_range(0, 3) == 0) begin
        set_in(0, 0);
        cyc();
      end
      if (!m_active) break;
      set_in(1, de && mg && w == nw - 1);
      cyc();
    end
    if (de && (!mg || nw == 0) && m_active) begin
      set_in(0, 1);
      cyc();
    end
    n = 0;
    while (m_active && n < 2 * TO + 10) begin
      set_in(0, 0);
      cyc();
      n++;
    end
    if (m_active) bound_fail("close_wait");
    set_in(0, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int w0, na, nl;
    rst_n = 0; daq_req = '0; daq_valid = '0; daq_end = '0; buf_free = '0;
    model_reset();
    #1;
    chk("rst_grant", daq_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", len, 0);
    repeat (2) cyc();
    rst_n = 1;
    buf_free = 100;
    daq_req = 4'b1111;
    repeat (5) serve(3, 1, 0, 0);
    chk("p1_grants", gq.size(), 5);
    for (int k = 0; k < 5; k++) chk("p1_order", k < gq.size() ? gq[k] : -1, exp_g[k]);
    chk("p1_lens", lq.size(), 5);
    foreach (lq[k]) chk("p1_len", lq[k], 3);
    chk("p1_words", wcnt, 15);
    daq_req = 4'b0010;
    serve(1, 1, 0, 0);
    gq.delete();
    daq_req = 4'b0011;
    serve(2, 1, 0, 0);
    serve(2, 1, 0, 0);
    chk("p2_first", gq.size() > 0 ? gq[0] : -1, 0);
    chk("p2_second", gq.size() > 1 ? gq[1] : -1, 1);
    daq_req = 4'b0001;
    buf_free = 63;
    repeat (5) begin
      cyc();
      chk("holdoff_grant", daq_grant, 0);
    end
    buf_free = 64;
    cyc();
    chk("free64_grant", daq_grant, 4'b0001);
    serve(2, 0, 0, 0);
    chk("to_len", lq[$], 2);
    chk("to_cause", aq.size() > 0 ? aq[$] : -1, 0);
    chk("to_busy", busy, 0);
    daq_req = 4'b0011;
    w0 = wcnt;
    serve(65, 0, 0, 0);
    chk("ovr_words", wcnt - w0, 64);
    chk("ovr_len", lq[$], 64);
    chk("ovr_cause", aq.size() > 0 ? aq[$] : -1, 1);
    cyc();
    chk("ovr_next_grant", daq_grant, 4'b0001);
    na = aq.size();
    serve(5, 1, 1, 0);
    chk("merge_len", lq[$], 5);
    chk("merge_noabort", aq.size(), na);
    daq_req = 4'b0010;
    for (int n = 0; n < 5 && !m_active; n++) cyc();
    if (!m_active) bound_fail("rst_grant_wait");
    set_in(1, 0);
    cyc();
    cyc();
    nl = lq.size();
    rst_n = 0;
    #1;
    chk("mid_rst_grant", daq_grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", wr_en, 0);
    chk("mid_rst_lwr", len_wr_en, 0);
    chk("mid_rst_abort", abort, 0);
    chk("mid_rst_sel", sel, 0);
    model_reset();
    set_in(0, 0);
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    chk("mid_rst_nolen", lq.size(), nl);
    noise_en = 1;
    for (int p = 0; p < 150; p++) begin
      daq_req = NDAQ'($urandom);
      if (daq_req == 0) daq_req = NDAQ'(1) << $urandom_range(0, NDAQ - 1);
      serve($urandom_range(0, 70), $urandom_range(0, 9) != 0, $urandom_range(0, 1), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
